// File: rtl/ccd_exposure_sequencer.sv
// ccd_exposure_sequencer: drives a CCD clock generator through a programmed
// number of exposures. Raises enable, shifts a 4-bit exposure code MSB first,
// counts phi_p rises and drops enable once the last readout pulse ends.
// Optional feature: define SEQ_WATCHDOG_EN to build a phi_p-activity watchdog
// that aborts the run and sets a sticky o_timeout flag.
module ccd_exposure_sequencer #(
  parameter int                FRAMES_W      = 8,
  parameter int                SETTLE_CYCLES = 4,
  parameter int                WDOG_W        = 24,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT    = 24'hFF_FFFF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [FRAMES_W-1:0] i_frames,
  input  logic [3:0]          i_exp_code,
  input  logic                i_phi_p,
  output logic                o_enable,
  output logic                o_f_select_serial,
  output logic                o_load_config,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_done,
  output logic [FRAMES_W-1:0] o_frame_cnt,
  output logic                o_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_LOAD, S_RUN, S_DRAIN, S_STOP} state_t;

  // One counter serves both the settle wait and the 4-bit shift phase.
  localparam int CNT_MAX = (SETTLE_CYCLES > 4) ? SETTLE_CYCLES : 4;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(3);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    set_cnt_q, set_cnt_d;
  logic [3:0]          code_q, code_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [FRAMES_W-1:0] frame_cnt_q, frame_cnt_d, cnt_inc;
  logic                frame_done_q, frame_done_d;
  logic                fsel_q, fsel_d;
  logic                enable_q, enable_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phi_q;
  logic                rise, fall, active, wdog_hit;

  assign rise   = i_phi_p & ~phi_q;
  assign fall   = ~i_phi_p & phi_q;
  // States where an abort (or a watchdog expiry) is honoured.
  assign active = (state_q != S_IDLE) && (state_q != S_STOP);

`ifdef SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  assign wdog_hit  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (wdog_q == WDOG_LIMIT);
  assign o_timeout = timeout_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
  assign wdog_hit    = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    set_cnt_d    = set_cnt_q;
    code_d       = code_q;
    frames_d     = frames_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    fsel_d       = 1'b0;
    cnt_inc      = frame_cnt_q + 1'b1;
`ifdef SEQ_WATCHDOG_EN
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
`endif
    if (active && (i_abort || wdog_hit)) begin
      // Abort path: straight to IDLE, count holds, no done pulse.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_start && !i_abort) begin
          state_d     = S_ARM;
          frames_d    = i_frames;
          code_d      = i_exp_code;
          frame_cnt_d = '0;
          set_cnt_d   = '0;
`ifdef SEQ_WATCHDOG_EN
          timeout_d   = 1'b0;
`endif
        end
        // The code register doubles as the serial shifter: its MSB is the
        // next bit to present.
        S_ARM: if (set_cnt_q == ARM_LAST) begin
          state_d   = S_LOAD;
          set_cnt_d = '0;
          fsel_d    = code_q[3];
          code_d    = {code_q[2:0], 1'b0};
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
        S_LOAD: if (set_cnt_q == LOAD_LAST) begin
          state_d = S_RUN;
`ifdef SEQ_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
          fsel_d    = code_q[3];
          code_d    = {code_q[2:0], 1'b0};
        end
        S_RUN: if (rise) begin
          frame_cnt_d  = cnt_inc;
          frame_done_d = 1'b1;
          if ((frames_q != '0) && (cnt_inc == frames_q)) state_d = S_DRAIN;
        end
        // Wait for the last readout pulse to end before releasing enable.
        S_DRAIN: if (fall) state_d = S_STOP;
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
`ifdef SEQ_WATCHDOG_EN
    if (wdog_hit) timeout_d = 1'b1;
    else if ((state_q == S_RUN) || (state_q == S_DRAIN))
      wdog_d = (rise | fall) ? '0 : wdog_q + 1'b1;
`endif
    enable_d = (state_d == S_ARM) || (state_d == S_LOAD) ||
               (state_d == S_RUN) || (state_d == S_DRAIN);
    load_d   = (state_d == S_LOAD);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_STOP);
  end

  // All state and outputs registered; async reset clears everything.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      set_cnt_q    <= '0;
      code_q       <= '0;
      frames_q     <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      fsel_q       <= 1'b0;
      enable_q     <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      phi_q        <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      set_cnt_q    <= set_cnt_d;
      code_q       <= code_d;
      frames_q     <= frames_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      fsel_q       <= fsel_d;
      enable_q     <= enable_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      phi_q        <= i_phi_p;
`ifdef SEQ_WATCHDOG_EN
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign o_enable          = enable_q;
  assign o_f_select_serial = fsel_q;
  assign o_load_config     = load_q;
  assign o_busy            = busy_q;
  assign o_frame_done      = frame_done_q;
  assign o_done            = done_q;
  assign o_frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_ccd_exposure_sequencer.sv
// Self-checking bench for ccd_exposure_sequencer: timeline-based reference
// model compared every cycle, plus directed literal checks and random runs.
// Define SEQ_WATCHDOG_EN to also exercise the watchdog (limit 100).
module tb_ccd_exposure_sequencer;
  localparam int S = 4;
`ifdef SEQ_WATCHDOG_EN
  localparam logic [23:0] LIM = 24'd100;
`else
  localparam logic [23:0] LIM = 24'hFF_FFFF;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       i_start = 0, i_abort = 0, i_phi_p = 0;
  logic [7:0] i_frames = 0;
  logic [3:0] i_exp_code = 0;
  logic       o_enable, o_fsel, o_load, o_busy, o_fdone, o_done, o_timeout;
  logic [7:0] o_cnt;

  int n_tests = 0, n_fail = 0;

  ccd_exposure_sequencer #(.FRAMES_W(8), .SETTLE_CYCLES(S), .WDOG_W(24), .WDOG_LIMIT(LIM)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_frames(i_frames), .i_exp_code(i_exp_code), .i_phi_p(i_phi_p),
    .o_enable(o_enable), .o_f_select_serial(o_fsel), .o_load_config(o_load),
    .o_busy(o_busy), .o_frame_done(o_fdone), .o_done(o_done),
    .o_frame_cnt(o_cnt), .o_timeout(o_timeout));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is described by its acceptance edge index; phase
  // follows from elapsed edges, counting/draining from observed phi_p edges.
  int n = 0, m_t0 = 0, p, q;
  logic m_busy = 0, m_stop = 0, m_drain = 0, m_to = 0, m_phi = 0, rise, fall, in_rd, wd_hit;
  logic [7:0] m_frames = 0, m_cnt = 0;
  logic [3:0] m_code = 0;
  logic e_en = 0, e_fsel = 0, e_load = 0, e_busy = 0, e_fdone = 0, e_done = 0;
`ifdef SEQ_WATCHDOG_EN
  int wd = 0;
`endif

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_stop = 0; m_drain = 0; m_cnt = 0; m_to = 0; m_phi = 0;
      e_en = 0; e_fsel = 0; e_load = 0; e_busy = 0; e_fdone = 0; e_done = 0;
    end else begin
      n = n + 1;
      rise = i_phi_p && !m_phi;
      fall = !i_phi_p && m_phi;
      e_fdone = 0;
      if (!m_busy) begin
        if (i_start && !i_abort) begin
          m_busy = 1; m_t0 = n; m_frames = i_frames; m_code = i_exp_code;
          m_cnt = 0; m_to = 0; m_drain = 0; m_stop = 0;
        end
      end else if (m_stop) begin
        m_busy = 0; m_stop = 0;
      end else begin
        p = n - 1 - m_t0;
        in_rd = (p >= S + 4);
`ifdef SEQ_WATCHDOG_EN
        wd_hit = in_rd && (wd == int'(LIM));
`else
        wd_hit = 0;
`endif
        if (i_abort || wd_hit) begin
          m_busy = 0;
          if (wd_hit) m_to = 1;
        end else begin
          if (in_rd) begin
            if (!m_drain) begin
              if (rise) begin
                m_cnt = m_cnt + 8'd1; e_fdone = 1;
                if (m_frames != 0 && m_cnt == m_frames) m_drain = 1;
              end
            end else if (fall) m_stop = 1;
`ifdef SEQ_WATCHDOG_EN
            wd = (rise || fall) ? 0 : wd + 1;
`endif
          end
`ifdef SEQ_WATCHDOG_EN
          if (p == S + 3) wd = 0;
`endif
        end
      end
      m_phi = i_phi_p;
      q = n - m_t0;
      e_busy = m_busy;
      e_done = m_busy && m_stop;
      e_en   = m_busy && !m_stop;
      e_load = m_busy && (q >= S) && (q < S + 4);
      e_fsel = e_load ? m_code[3 - (q - S)] : 1'b0;
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("enable", o_enable, e_en);
    chk("fsel", o_fsel, e_fsel);
    chk("load_config", o_load, e_load);
    chk("busy", o_busy, e_busy);
    chk("frame_done", o_fdone, e_fdone);
    chk("done", o_done, e_done);
    chk("frame_cnt", o_cnt, m_cnt);
    chk("timeout", o_timeout, m_to);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic start(input logic [7:0] f, input logic [3:0] c);
    i_frames = f; i_exp_code = c; i_start = 1; i_abort = 0;
    tick();
    i_start = 0;
  endtask

  task automatic pulse(input int hi, input int lo);
    i_phi_p = 1; repeat (hi) tick();
    i_phi_p = 0; repeat (lo) tick();
  endtask

  task automatic to_idle();
    for (int k = 0; k < 30; k++) begin
      if (!o_busy) break;
      tick();
    end
    if (o_busy) begin i_abort = 1; tick(); i_abort = 0; end
    tick();
  endtask

  initial begin
    logic [3:0] bits;
    int first, nload, k;

    // Reset state
    repeat (3) tick();
    chk("rst_enable", o_enable, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", o_cnt, 0);
    rst_n = 1;
    repeat (3) tick();
    chk("idle_busy", o_busy, 0);

    // Two-frame run, code 1011
    start(8'd2, 4'b1011);
    chk("arm_enable", o_enable, 1);
    bits = 0; first = -1; nload = 0;
    for (int i = 0; i < S + 7; i++) begin
      if (o_load) begin
        if (first < 0) first = i;
        bits = {bits[2:0], o_fsel};
        nload++;
      end
      tick();
    end
    chk("load_first", first, S);
    chk("load_len", nload, 4);
    chk("load_bits", bits, 4'b1011);
    pulse(3, 3);
    chk("cnt_one", o_cnt, 1);
    i_phi_p = 1; tick();
    chk("cnt_two", o_cnt, 2);
    chk("fdone_two", o_fdone, 1);
    tick(); tick();
    i_phi_p = 0; tick();
    chk("stop_done", o_done, 1);
    chk("stop_enable", o_enable, 0);
    tick();
    chk("after_stop_busy", o_busy, 0);
    chk("hold_cnt", o_cnt, 2);

    // Continuous mode with counter wrap
    start(8'd0, 4'hA);
    repeat (S + 5) tick();
    for (int i = 0; i < 300; i++) pulse(1, 1);
    chk("wrap_cnt", o_cnt, 44);
    chk("cont_enable", o_enable, 1);
    i_abort = 1; tick(); i_abort = 0;
    chk("abort_busy", o_busy, 0);

    // Abort in LOAD cycle 2
    start(8'd3, 4'h5);
    repeat (S + 2) tick();
    chk("load_c2", o_load, 1);
    i_abort = 1; tick(); i_abort = 0;
    chk("abl_enable", o_enable, 0);
    chk("abl_load", o_load, 0);
    chk("abl_busy", o_busy, 0);
    chk("abl_done", o_done, 0);
    i_start = 1; i_abort = 1; tick(); tick();
    chk("start_abort_busy", o_busy, 0);
    i_start = 0; i_abort = 0; tick();

`ifdef SEQ_WATCHDOG_EN
    start(8'd0, 4'h9);
    repeat (S + 5) tick();
    i_phi_p = 1;
    k = 0;
    while (o_busy && k < 200) begin tick(); k++; end
    chk("wdog_window", (k >= 95 && k <= 110), 1);
    chk("wdog_timeout", o_timeout, 1);
    chk("wdog_enable", o_enable, 0);
    i_phi_p = 0; tick();
    start(8'd1, 4'h2);
    chk("wdog_clear", o_timeout, 0);
    i_abort = 1; tick(); i_abort = 0; tick();
`else
    k = 0;
`endif

    // Async reset mid-run, then a clean single exposure
    start(8'd5, 4'h3);
    repeat (S + 6) tick();
    pulse(1, 2);
    #2 rst_n = 0;
    #1;
    chk("arst_enable", o_enable, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_cnt", o_cnt, 0);
    tick(); tick();
    rst_n = 1; tick();
    start(8'd1, 4'h6);
    repeat (S + 5) tick();
    i_phi_p = 1; tick(); tick();
    i_phi_p = 0; tick();
    chk("single_done", o_done, 1);
    tick();
    chk("single_cnt", o_cnt, 1);
    chk("single_busy", o_busy, 0);

    // Random runs against the model
    for (int t = 0; t < 40; t++) begin
      start(8'($urandom_range(0, 4)), 4'($urandom));
      k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) begin
        i_start = ($urandom_range(0, 3) == 0);
        i_frames = 8'($urandom_range(0, 3));
        pulse($urandom_range(1, 3), $urandom_range(1, 3));
      end
      i_start = 0;
      if ($urandom_range(0, 3) == 0) begin i_abort = 1; tick(); i_abort = 0; end
      to_idle();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ccd_exposure_sequencer.md
# ccd_exposure_sequencer

Sequences the CCD clock generator through a programmed number of exposures. On a start command it raises the generator enable and shifts a 4-bit exposure-time code into the generator's serial frequency-select port. It then counts completed exposures from the generator's `phi_p` output and drops the enable after the last one. It sits beside the generator on the same clock and drives its `enable`, `f_select_serial` and `load_config` inputs directly.

## Interface
- `FRAMES_W`, 8: width of the frame-count request and the frame counter.
- `SETTLE_CYCLES`, 4: cycles enable is held before config shifting starts (≥1).
- `WDOG_W`, 24: watchdog counter width.
- `WDOG_LIMIT`, 24'hFF_FFFF: cycles without a `phi_p` edge before timeout.
- `wb_clk_i` in 1: clock, shared with the generator clock.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low.
- `i_start` in 1: start request, sampled only in IDLE.
- `i_abort` in 1: abort; level, acted on in any non-IDLE state.
- `i_frames` in FRAMES_W: exposures to run; 0 = continuous.
- `i_exp_code` in 4: exposure-time code sent to the generator.
- `i_phi_p` in 1: generator `phi_p` output.
- `o_enable` out 1: generator enable.
- `o_f_select_serial` out 1: serial config data, MSB first.
- `o_load_config` out 1: serial config shift strobe.
- `o_busy` out 1: high in every state except IDLE.
- `o_frame_done` out 1: one-cycle pulse per counted exposure.
- `o_done` out 1: one-cycle pulse on normal completion.
- `o_frame_cnt` out FRAMES_W: exposures counted since the last accepted start.
- `o_timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, ARM, LOAD, RUN, DRAIN, STOP. All outputs are registered.
- Reset: state = IDLE. Every output is 0, the internal `phi_q` register is 0 and the latched request registers are 0.
- IDLE, `i_start`=1 and `i_abort`=0: latch `i_frames` and `i_exp_code`, clear `o_frame_cnt` and `o_timeout`, go to ARM. If `i_start` and `i_abort` are both 1, stay in IDLE.
- ARM: `o_enable`=1 for SETTLE_CYCLES cycles, then go to LOAD. The generator clears its shift register while enable is low, so enable must be high before shifting.
- LOAD: exactly 4 cycles with `o_load_config`=1. In cycle k (k=0..3), `o_f_select_serial` = `code[3-k]`. Then go to RUN with `o_load_config`=0 and `o_f_select_serial`=0.
- Edge detection: `phi_q` <= `i_phi_p` every cycle. Rise = `i_phi_p & ~phi_q`. Fall = `~i_phi_p & phi_q`.
- RUN: on each rise, increment `o_frame_cnt` (wraps modulo 2^FRAMES_W) and pulse `o_frame_done` in the next cycle.
  - If frames≠0 and the new count equals frames, go to DRAIN.
  - If frames=0, never leave RUN except by abort or timeout.
- DRAIN: on a fall (the last readout pulse has ended), go to STOP.
- STOP: `o_enable`=0 for one cycle and `o_done`=1, then go to IDLE.
- Abort in ARM, LOAD, RUN or DRAIN: go directly to IDLE next cycle.
  - `o_enable`, `o_load_config` and `o_f_select_serial` go to 0.
  - No `o_done` pulse. `o_frame_cnt` holds.
- `i_start` while busy is ignored.
- `o_frame_cnt` holds its final value in IDLE until the next accepted start.

## Timing
- Start accepted at edge T: `o_enable`=1 from T+1.
- LOAD occupies T+1+SETTLE_CYCLES through T+4+SETTLE_CYCLES. RUN begins at T+5+SETTLE_CYCLES.
- `i_phi_p` rise at edge E: `o_frame_cnt` updates and `o_frame_done`=1 at E+1, after the one-cycle `phi_q` delay.
- Final rise at E: the DRAIN transition is visible at E+1. The fall at edge F gives STOP at F+1 (`o_enable`=0, `o_done`=1) and IDLE at F+2.
- A `phi_p` rise is ignored outside RUN. `phi_p` being high during ARM/LOAD (generator INITIAL_SETUP) does not count as an exposure.
- Asynchronous reset mid-operation: all outputs go to 0 immediately, which stops the generator.

## Configuration
- `SEQ_WATCHDOG_EN` defined: the watchdog counter (WDOG_W bits) runs in RUN and DRAIN.
  - It clears on entering RUN and on every `phi_p` rise or fall.
  - On reaching WDOG_LIMIT: set `o_timeout`=1 (sticky) and take the abort path to IDLE.
- `SEQ_WATCHDOG_EN` undefined: no counter is built, `o_timeout` is tied to 0 and the port list is unchanged.

## Test plan
- Reset: with `wb_rst_ni`=0, all outputs are 0. Release reset with `i_start`=0: the block stays IDLE and `o_busy`=0.
- Start with `i_frames`=2 and `i_exp_code`=4'b1011, SETTLE_CYCLES=4 → `o_load_config` is high for 4 cycles starting 5 cycles after start, and the serial bits are 1,0,1,1. Then inject `phi_p` rises: `o_frame_cnt` goes to 1, then 2. The second fall gives `o_done` and `o_enable`=0 in the same cycle.
- `i_frames`=0 with 300 injected `phi_p` pulses → `o_frame_cnt`=44 (wrapped), `o_enable` stays 1 and there is no `o_done`.
- Abort in LOAD cycle 2 → next cycle `o_enable`=0, `o_load_config`=0 and `o_busy`=0, with no `o_done`. Then `i_start` and `i_abort` high together in IDLE → no start.
- `SEQ_WATCHDOG_EN` defined, WDOG_LIMIT=100, `phi_p` held high in RUN → `o_timeout`=1 and `o_enable`=0 about 100 cycles after RUN entry. A new start clears `o_timeout`.
- Assert `wb_rst_ni`=0 mid-RUN, then restart with `i_frames`=1 → a clean single exposure with `o_frame_cnt`=1.
